id_alloc_arb: RTL and testbench
===============================

# id_alloc_arb

Arbitration and accounting front-end for the 2-write/1-read ID free-pool.
- Shares the pool's single allocate port among `NUM_REQ` requesters by round-robin.
- Funnels the requesters' ID releases onto the pool's two free lanes, also round-robin.
- Enforces a per-requester cap on outstanding IDs and flags underflow.
- Sits between the L1D miss/request sources and the pool instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, 5, ID width; equals the pool `width`
- `USE_W`, 4, pool usage width; equals the pool `ptr_sz+1`
- `MAX_OUT`, 4, maximum outstanding IDs per requester (1..15)
- `RESERVE`, 2, IDs held back for requester 0 (only with the macro)

- `clk` in 1 — clock
- `rst_n` in 1 — asynchronous, active-low reset
- `req_vld` in NUM_REQ — allocate request per requester
- `req_rdy` out NUM_REQ — one-hot grant, combinational
- `rsp_vld` out NUM_REQ — registered allocate response
- `rsp_id` out ID_W — ID for the single asserted `rsp_vld` bit
- `rel_vld` in NUM_REQ — release request per requester
- `rel_id` in NUM_REQ*ID_W — released ID; requester r uses slice [r*ID_W +: ID_W]
- `rel_rdy` out NUM_REQ — release accepted, combinational
- `pool_p_srdy` in 1 — pool has a free ID
- `pool_p_drdy` out 1 — pop the pool
- `pool_p_data` in ID_W — ID at the pool head
- `pool_usage` in USE_W — free-ID count in the pool
- `pool_c_srdy` out 2 — free-lane valids
- `pool_c_drdy` in 2 — free-lane readies
- `pool_c_data` out 2*ID_W — free-lane data; lane1 in the upper half
- `out_cnt` out NUM_REQ*4 — outstanding-ID count per requester
- `err_underflow` out 1 — sticky; set by a release while the count is 0

## Operation
**Allocation**
- Eligible(r) = `req_vld[r]` & (`cnt[r]` < `MAX_OUT`).
- Grant the first eligible requester at or after `alloc_ptr`, searching with wrap. Grant only when `pool_p_srdy`=1.
- `pool_p_drdy` = |`req_rdy`.
- On grant g:
  - `alloc_ptr` <= (g+1) mod NUM_REQ.
  - `rsp_vld` <= onehot(g); `rsp_id` <= `pool_p_data`.
- With no grant: `rsp_vld` <= 0 and `rsp_id` holds its value.

**Release**
- Pick up to two `rel_vld` requesters, scanning from `rel_ptr` with wrap. The first pick (a) goes to lane0, the second (b) to lane1.
- One candidate: `pool_c_srdy`=2'b01.
- Two candidates: `pool_c_srdy`=2'b11.
- `rel_rdy[a]` = `pool_c_drdy[0]`; `rel_rdy[b]` = `pool_c_drdy[1]` & `pool_c_srdy[1]`.
- `rel_ptr` advances to (last accepted requester + 1) mod NUM_REQ. With no acceptance it is unchanged.

**Counters**
- `cnt[r]` += grant(r) − rel_accept(r).
- Allocate and release for the same requester in the same cycle leave it unchanged.
- Eligibility uses the registered count. A release in the same cycle does not free a slot early.
- A release accepted while `cnt[r]`=0:
  - sets `err_underflow`;
  - leaves `cnt[r]` at 0 (no wrap);
  - is still forwarded to the pool.

## Timing
- Reset values: `alloc_ptr`=0, `rel_ptr`=0, `rsp_vld`=0, `rsp_id`=0, all `cnt`=0, `err_underflow`=0.
- Combinational outputs, which follow their inputs as soon as reset releases: `req_rdy`, `pool_p_drdy`, `pool_c_*`, `rel_rdy`.
- Allocate latency: grant in cycle T, `rsp_vld`/`rsp_id` in cycle T+1. Back-to-back grants give one response per cycle.
- Release has zero latency. The pool write occurs in the cycle `rel_rdy` is high.
- `pool_p_srdy`=0: no grant, pointer frozen.
- Pool full (`pool_c_drdy`=0): no `rel_rdy`, counters hold, requesters must hold `rel_vld`/`rel_id`.
- Reset asserted mid-operation clears all state immediately. An in-flight `rsp_vld` is dropped.

## Configuration
- `ID_ALLOC_ARB_RESERVE_EN` defined: requesters 1..NUM_REQ-1 are ineligible while `pool_usage` <= `RESERVE`. Requester 0 remains eligible down to empty.
- Macro undefined: no reservation; `RESERVE` is ignored and `pool_usage` is unused.

## Test plan
- Round-robin allocation: all four `req_vld`=1, pool delivers IDs 3,4,5,6 → grants to requesters 0,1,2,3 in order. Each `rsp_id` appears one cycle after its grant.
- Cap: requester 2 alone takes 4 IDs (MAX_OUT=4) → 5th request gets no `req_rdy`. One release from requester 2 → the next cycle grants it.
- Dual release: requesters 1 and 3 release IDs 9 and 12 with `pool_c_drdy`=2'b11 → `pool_c_srdy`=2'b11, lane0=9, lane1=12, `rel_ptr`=0. Then with `pool_c_drdy`=2'b01 only the lane0 requester is accepted.
- Underflow: requester 0 releases ID 7 with `cnt[0]`=0 → `err_underflow`=1 and stays set, `cnt[0]`=0, ID 7 is still forwarded to the pool.
- Reserve (macro on, RESERVE=2): `pool_usage`=2, requesters 0 and 1 both request → only requester 0 is granted. With `pool_usage`=3 → round-robin resumes.
- Reset mid-grant: drop `rst_n` in the cycle after a grant → `rsp_vld`=0 and `out_cnt`=0 immediately; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/id_alloc_arb_if.sv
// Requester- and pool-side handshake bundle for id_alloc_arb.
// slave: the arbiter's view; master: the requesters/pool view.
interface id_alloc_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned USE_W   = 4
);
  logic [NUM_REQ-1:0]      req_vld;
  logic [NUM_REQ-1:0]      req_rdy;
  logic [NUM_REQ-1:0]      rsp_vld;
  logic [ID_W-1:0]         rsp_id;
  logic [NUM_REQ-1:0]      rel_vld;
  logic [NUM_REQ*ID_W-1:0] rel_id;
  logic [NUM_REQ-1:0]      rel_rdy;
  logic                    pool_p_srdy;
  logic                    pool_p_drdy;
  logic [ID_W-1:0]         pool_p_data;
  logic [USE_W-1:0]        pool_usage;
  logic [1:0]              pool_c_srdy;
  logic [1:0]              pool_c_drdy;
  logic [2*ID_W-1:0]       pool_c_data;
  logic [NUM_REQ*4-1:0]    out_cnt;
  logic                    err_underflow;

  modport slave (
    input  req_vld, rel_vld, rel_id, pool_p_srdy, pool_p_data, pool_usage, pool_c_drdy,
    output req_rdy, rsp_vld, rsp_id, rel_rdy, pool_p_drdy, pool_c_srdy, pool_c_data,
           out_cnt, err_underflow
  );

  modport master (
    output req_vld, rel_vld, rel_id, pool_p_srdy, pool_p_data, pool_usage, pool_c_drdy,
    input  req_rdy, rsp_vld, rsp_id, rel_rdy, pool_p_drdy, pool_c_srdy, pool_c_data,
           out_cnt, err_underflow
  );
endinterface

// File: rtl/id_alloc_arb.sv
// Round-robin allocate/release front-end for the 2-write/1-read ID free-pool.
// Optional macro ID_ALLOC_ARB_RESERVE_EN holds RESERVE IDs back for requester 0.
module id_alloc_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 5,
  parameter int unsigned USE_W   = 4,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned RESERVE = 2
) (
  input logic           clk,
  input logic           rst_n,
  id_alloc_arb_if.slave bus
);
  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam logic [3:0]  CNT_MAX = 4'(MAX_OUT);

  logic [PTR_W-1:0] r_alloc_ptr;
  logic [PTR_W-1:0] r_rel_ptr;
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [ID_W-1:0]  r_rsp_id;
  logic [3:0]       r_cnt [NUM_REQ];
  logic             r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_gnt_any;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_a_any, w_b_any;
  logic [PTR_W-1:0]   w_a_idx, w_b_idx;
  logic               w_a_acc, w_b_acc;
  logic [NUM_REQ-1:0] w_rel_acc;
  logic               w_resv_ok;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned ofs);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(ofs);
    if (s >= (PTR_W+1)'(NUM_REQ)) s = s - (PTR_W+1)'(NUM_REQ);
    return s[PTR_W-1:0];
  endfunction

`ifdef ID_ALLOC_ARB_RESERVE_EN
  assign w_resv_ok = (bus.pool_usage > USE_W'(RESERVE));
`else
  logic w_unused_usage;
  assign w_resv_ok      = 1'b1;
  assign w_unused_usage = ^bus.pool_usage;
`endif

  // Eligibility looks at the registered count, so a same-cycle release never frees a slot early.
  always_comb begin
    w_elig = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      w_elig[r] = bus.req_vld[r] && (r_cnt[r] < CNT_MAX) && ((r == 0) || w_resv_ok);
    end
  end

  always_comb begin
    logic [PTR_W-1:0] k;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = wrap_add(r_alloc_ptr, i);
      if (!w_gnt_any && w_elig[k] && bus.pool_p_srdy) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = k;
      end
    end
  end

  assign w_gnt           = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;
  assign bus.req_rdy     = w_gnt;
  assign bus.pool_p_drdy = w_gnt_any;

  // First two releasing requesters in round-robin order map to lane0 and lane1.
  always_comb begin
    logic [PTR_W-1:0] k;
    w_a_any = 1'b0;
    w_b_any = 1'b0;
    w_a_idx = '0;
    w_b_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = wrap_add(r_rel_ptr, i);
      if (bus.rel_vld[k]) begin
        if (!w_a_any) begin
          w_a_any = 1'b1;
          w_a_idx = k;
        end else if (!w_b_any) begin
          w_b_any = 1'b1;
          w_b_idx = k;
        end
      end
    end
  end

  assign w_a_acc         = w_a_any && bus.pool_c_drdy[0];
  assign w_b_acc         = w_b_any && bus.pool_c_drdy[1];
  assign bus.pool_c_srdy = {w_b_any, w_a_any};
  assign bus.pool_c_data = {(w_b_any ? bus.rel_id[w_b_idx*ID_W +: ID_W] : ID_W'(0)),
                            (w_a_any ? bus.rel_id[w_a_idx*ID_W +: ID_W] : ID_W'(0))};

  always_comb begin
    w_rel_acc = '0;
    if (w_a_acc) w_rel_acc[w_a_idx] = 1'b1;
    if (w_b_acc) w_rel_acc[w_b_idx] = 1'b1;
  end

  assign bus.rel_rdy = w_rel_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_ptr <= '0;
      r_rel_ptr   <= '0;
      r_rsp_vld   <= '0;
      r_rsp_id    <= '0;
      r_err       <= 1'b0;
      for (int unsigned r = 0; r < NUM_REQ; r++) r_cnt[r] <= '0;
    end else begin
      if (w_gnt_any) begin
        r_alloc_ptr <= wrap_add(w_gnt_idx, 1);
        r_rsp_vld   <= w_gnt;
        r_rsp_id    <= bus.pool_p_data;
      end else begin
        r_rsp_vld <= '0;
      end
      if (w_b_acc)      r_rel_ptr <= wrap_add(w_b_idx, 1);
      else if (w_a_acc) r_rel_ptr <= wrap_add(w_a_idx, 1);
      for (int unsigned r = 0; r < NUM_REQ; r++) begin
        if (w_rel_acc[r] && (r_cnt[r] == 4'd0)) r_err <= 1'b1;
        case ({w_gnt[r], w_rel_acc[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + 4'd1;
          2'b01:   if (r_cnt[r] != 4'd0) r_cnt[r] <= r_cnt[r] - 4'd1;
          default: r_cnt[r] <= r_cnt[r];
        endcase
      end
    end
  end

  always_comb begin
    bus.out_cnt = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) bus.out_cnt[r*4 +: 4] = r_cnt[r];
  end

  assign bus.rsp_vld       = r_rsp_vld;
  assign bus.rsp_id        = r_rsp_id;
  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_id_alloc_arb.sv
// Directed, table-driven bench for id_alloc_arb (NUM_REQ=4, ID_W=5, MAX_OUT=4).
module tb_id_alloc_arb;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  id_alloc_arb_if #(.NUM_REQ(4), .ID_W(5), .USE_W(4)) bus ();

  id_alloc_arb #(
    .NUM_REQ(4), .ID_W(5), .USE_W(4), .MAX_OUT(4), .RESERVE(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  rel;
    logic [19:0] rel_id;
    logic        p_srdy;
    logic [4:0]  p_data;
    logic [1:0]  c_drdy;
    logic [3:0]  e_req_rdy;
    logic [3:0]  e_rel_rdy;
    logic [1:0]  e_c_srdy;
    logic [9:0]  e_c_data;
    logic [3:0]  e_rsp_vld;
    logic [4:0]  e_rsp_id;
    logic [15:0] e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(
    input logic [3:0] req, input logic [3:0] rel, input logic [19:0] rel_id,
    input logic p_srdy, input logic [4:0] p_data, input logic [1:0] c_drdy,
    input logic [3:0] e_req_rdy, input logic [3:0] e_rel_rdy, input logic [1:0] e_c_srdy,
    input logic [9:0] e_c_data, input logic [3:0] e_rsp_vld, input logic [4:0] e_rsp_id,
    input logic [15:0] e_cnt, input logic e_err);
    vec_t v;
    v.req = req; v.rel = rel; v.rel_id = rel_id; v.p_srdy = p_srdy;
    v.p_data = p_data; v.c_drdy = c_drdy; v.e_req_rdy = e_req_rdy;
    v.e_rel_rdy = e_rel_rdy; v.e_c_srdy = e_c_srdy; v.e_c_data = e_c_data;
    v.e_rsp_vld = e_rsp_vld; v.e_rsp_id = e_rsp_id; v.e_cnt = e_cnt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] rel, input logic [19:0] rel_id,
                       input logic p_srdy, input logic [4:0] p_data, input logic [1:0] c_drdy,
                       input logic [3:0] usage);
    bus.req_vld     = req;
    bus.rel_vld     = rel;
    bus.rel_id      = rel_id;
    bus.pool_p_srdy = p_srdy;
    bus.pool_p_data = p_data;
    bus.pool_c_drdy = c_drdy;
    bus.pool_usage  = usage;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(4'b0, 4'b0, 20'd0, 1'b0, 5'd0, 2'b00, 4'd8);

    // req  rel  rel_id{r3,r2,r1,r0}  srdy data drdy | req_rdy rel_rdy c_srdy c_data rsp_vld rsp_id cnt err
    vecs[0]  = mk(4'b0000, 4'b0000, 20'd0,                       1, 5'd3,  2'b11, 4'b0000, 4'b0000, 2'b00, 10'd0,   4'b0000, 5'd0,  16'h0000, 0);
    vecs[1]  = mk(4'b1111, 4'b0000, 20'd0,                       1, 5'd3,  2'b11, 4'b0001, 4'b0000, 2'b00, 10'd0,   4'b0001, 5'd3,  16'h0001, 0);
    vecs[2]  = mk(4'b1111, 4'b0000, 20'd0,                       1, 5'd4,  2'b11, 4'b0010, 4'b0000, 2'b00, 10'd0,   4'b0010, 5'd4,  16'h0011, 0);
    vecs[3]  = mk(4'b1111, 4'b0000, 20'd0,                       1, 5'd5,  2'b11, 4'b0100, 4'b0000, 2'b00, 10'd0,   4'b0100, 5'd5,  16'h0111, 0);
    vecs[4]  = mk(4'b1111, 4'b0000, 20'd0,                       1, 5'd6,  2'b11, 4'b1000, 4'b0000, 2'b00, 10'd0,   4'b1000, 5'd6,  16'h1111, 0);
    vecs[5]  = mk(4'b0000, 4'b0000, 20'd0,                       1, 5'd7,  2'b11, 4'b0000, 4'b0000, 2'b00, 10'd0,   4'b0000, 5'd6,  16'h1111, 0);
    vecs[6]  = mk(4'b0000, 4'b1010, {5'd12, 5'd0, 5'd9, 5'd0},   1, 5'd7,  2'b11, 4'b0000, 4'b1010, 2'b11, 10'h189, 4'b0000, 5'd6,  16'h0101, 0);
    vecs[7]  = mk(4'b0000, 4'b0101, {5'd0, 5'd8, 5'd0, 5'd7},    1, 5'd7,  2'b01, 4'b0000, 4'b0001, 2'b11, 10'h107, 4'b0000, 5'd6,  16'h0100, 0);
    vecs[8]  = mk(4'b0000, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd7},    1, 5'd7,  2'b11, 4'b0000, 4'b0001, 2'b01, 10'd7,   4'b0000, 5'd6,  16'h0100, 1);
    vecs[9]  = mk(4'b0000, 4'b0000, 20'd0,                       1, 5'd7,  2'b11, 4'b0000, 4'b0000, 2'b00, 10'd0,   4'b0000, 5'd6,  16'h0100, 1);
    vecs[10] = mk(4'b0100, 4'b0000, 20'd0,                       1, 5'd10, 2'b11, 4'b0100, 4'b0000, 2'b00, 10'd0,   4'b0100, 5'd10, 16'h0200, 1);
    vecs[11] = mk(4'b0100, 4'b0000, 20'd0,                       1, 5'd11, 2'b11, 4'b0100, 4'b0000, 2'b00, 10'd0,   4'b0100, 5'd11, 16'h0300, 1);
    vecs[12] = mk(4'b0100, 4'b0000, 20'd0,                       1, 5'd12, 2'b11, 4'b0100, 4'b0000, 2'b00, 10'd0,   4'b0100, 5'd12, 16'h0400, 1);
    vecs[13] = mk(4'b0100, 4'b0000, 20'd0,                       1, 5'd13, 2'b11, 4'b0000, 4'b0000, 2'b00, 10'd0,   4'b0000, 5'd12, 16'h0400, 1);
    vecs[14] = mk(4'b0100, 4'b0100, {5'd0, 5'd10, 5'd0, 5'd0},   1, 5'd13, 2'b11, 4'b0000, 4'b0100, 2'b01, 10'd10,  4'b0000, 5'd12, 16'h0300, 1);
    vecs[15] = mk(4'b0100, 4'b0000, 20'd0,                       1, 5'd14, 2'b11, 4'b0100, 4'b0000, 2'b00, 10'd0,   4'b0100, 5'd14, 16'h0400, 1);
    vecs[16] = mk(4'b1111, 4'b0000, 20'd0,                       0, 5'd14, 2'b11, 4'b0000, 4'b0000, 2'b00, 10'd0,   4'b0000, 5'd14, 16'h0400, 1);
    vecs[17] = mk(4'b1011, 4'b0000, 20'd0,                       1, 5'd15, 2'b11, 4'b1000, 4'b0000, 2'b00, 10'd0,   4'b1000, 5'd15, 16'h1400, 1);
    vecs[18] = mk(4'b0000, 4'b0100, {5'd0, 5'd20, 5'd0, 5'd0},   1, 5'd15, 2'b00, 4'b0000, 4'b0000, 2'b01, 10'd20,  4'b0000, 5'd15, 16'h1400, 1);
    vecs[19] = mk(4'b1000, 4'b1000, {5'd15, 5'd0, 5'd0, 5'd0},   1, 5'd16, 2'b11, 4'b1000, 4'b1000, 2'b01, 10'd15,  4'b1000, 5'd16, 16'h1400, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("reset rsp_id",  32'(bus.rsp_id),  32'd0);
    chk("reset out_cnt", 32'(bus.out_cnt), 32'd0);
    chk("reset err",     32'(bus.err_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].req, vecs[i].rel, vecs[i].rel_id, vecs[i].p_srdy, vecs[i].p_data,
            vecs[i].c_drdy, 4'd8);
      #1;
      chk($sformatf("v%0d req_rdy", i),     32'(bus.req_rdy),     32'(vecs[i].e_req_rdy));
      chk($sformatf("v%0d pool_p_drdy", i), 32'(bus.pool_p_drdy), 32'(|vecs[i].e_req_rdy));
      chk($sformatf("v%0d rel_rdy", i),     32'(bus.rel_rdy),     32'(vecs[i].e_rel_rdy));
      chk($sformatf("v%0d pool_c_srdy", i), 32'(bus.pool_c_srdy), 32'(vecs[i].e_c_srdy));
      chk($sformatf("v%0d pool_c_data", i), 32'(bus.pool_c_data), 32'(vecs[i].e_c_data));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_vld", i),  32'(bus.rsp_vld),       32'(vecs[i].e_rsp_vld));
      chk($sformatf("v%0d rsp_id", i),   32'(bus.rsp_id),        32'(vecs[i].e_rsp_id));
      chk($sformatf("v%0d out_cnt", i),  32'(bus.out_cnt),       32'(vecs[i].e_cnt));
      chk($sformatf("v%0d err", i),      32'(bus.err_underflow), 32'(vecs[i].e_err));
    end

    // Reset in the cycle after a grant: response and counts vanish at once.
    @(negedge clk);
    drive(4'b0010, 4'b0000, 20'd0, 1'b1, 5'd17, 2'b11, 4'd8);
    #1;
    chk("rstseq grant", 32'(bus.req_rdy), 32'h2);
    @(posedge clk);
    #1;
    chk("rstseq rsp_vld pre", 32'(bus.rsp_vld), 32'h2);
    chk("rstseq cnt pre",     32'(bus.out_cnt), 32'h1410);
    drive(4'b0000, 4'b0000, 20'd0, 1'b1, 5'd17, 2'b11, 4'd8);
    rst_n = 1'b0;
    #1;
    chk("rstseq rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rstseq rsp_id",  32'(bus.rsp_id),  32'd0);
    chk("rstseq cnt",     32'(bus.out_cnt), 32'd0);
    chk("rstseq err",     32'(bus.err_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(4'b1111, 4'b0000, 20'd0, 1'b1, 5'd18, 2'b11, 4'd8);
    #1;
    chk("rstseq first grant", 32'(bus.req_rdy), 32'h1);
    @(posedge clk);
    #1;
    chk("rstseq first rsp_vld", 32'(bus.rsp_vld), 32'h1);
    chk("rstseq first rsp_id",  32'(bus.rsp_id),  32'd18);

`ifdef ID_ALLOC_ARB_RESERVE_EN
    @(negedge clk);
    drive(4'b0011, 4'b0000, 20'd0, 1'b1, 5'd19, 2'b11, 4'd2);
    #1;
    chk("resv low usage", 32'(bus.req_rdy), 32'h1);
    @(posedge clk);
    @(negedge clk);
    drive(4'b0011, 4'b0000, 20'd0, 1'b1, 5'd20, 2'b11, 4'd3);
    #1;
    chk("resv usage 3", 32'(bus.req_rdy), 32'h2);
    @(posedge clk);
`endif

    @(negedge clk);
    drive(4'b0, 4'b0, 20'd0, 1'b0, 5'd0, 2'b00, 4'd8);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
